// File: rtl/tt_bin_clock_input_cond.sv
// Input conditioner for the binary clock core: synchronises and debounces the
// raw board switches and buttons, presents the time-set and inc/dec levels,
// and turns hour/minute/seconds button presses into single-cycle step pulses
// with hold-to-auto-repeat.
module tt_bin_clock_input_cond #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 3,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_PERIOD   = 10
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic time_set_sw_i,
  input  logic id_sw_i,
  input  logic hour_btn_i,
  input  logic minute_btn_i,
  input  logic seconds_btn_i,
  output logic time_set_o,
  output logic id_switch_o,
  output logic hour_id_o,
  output logic minute_id_o,
  output logic seconds_id_o
);

  localparam int NIN = 5;
  localparam int DCW = $clog2(DEBOUNCE_CYCLES) + 1;
  // REPEAT_DELAY >= REPEAT_PERIOD, so one width covers both repeat counts.
  localparam int RCW = $clog2(REPEAT_DELAY) + 1;
  localparam logic [DCW-1:0] DB_LAST     = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  // Bit order of every 5-bit input vector: [0]=time_set, [1]=id,
  // [2]=hour, [3]=minute, [4]=seconds.
  logic [NIN-1:0] raw;
  assign raw = {seconds_btn_i, minute_btn_i, hour_btn_i, id_sw_i, time_set_sw_i};

  logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
  logic [NIN-1:0]                  sync_s;
  logic [NIN-1:0]                  deb_q;
  logic [DCW-1:0]                  dcnt_q [NIN];

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: shift each raw input through SYNC_STAGES flops.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Debounce: the level follows the synchronised input only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      deb_q <= '0;
      for (int i = 0; i < NIN; i++) dcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NIN; i++) begin
        if (sync_s[i] != deb_q[i]) begin
          if (dcnt_q[i] == DB_LAST) begin
            deb_q[i]  <= sync_s[i];
            dcnt_q[i] <= '0;
          end else begin
            dcnt_q[i] <= dcnt_q[i] + DCW'(1);
          end
        end else begin
          dcnt_q[i] <= '0;
        end
      end
    end
  end

  assign time_set_o  = deb_q[0];
  assign id_switch_o = deb_q[1];

  // Step FSM signals; button vectors are [0]=hour, [1]=minute, [2]=seconds.
  state_e         state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [2:0]     owner_q, owner_d;
  logic [2:0]     btn_prev_q;
  logic [2:0]     pulse_q, pulse_d;
  logic [2:0]     btn, rise;
  logic           press_ok, abort, fire;

  assign btn  = deb_q[4:2];
  assign rise = btn & ~btn_prev_q;
  // A press counts only if it is the sole rising button and nothing else is
  // held; a button already held when time-set rises has no rise and so waits.
  assign press_ok = deb_q[0] && $onehot(rise) && (btn == rise);
  // Leaving time-set, releasing the owner or touching any other button ends
  // the sequence.
  assign abort = !deb_q[0] || (btn != owner_q);

  // FSM state register together with repeat counter, owner and edge history.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_IDLE;
      rcnt_q     <= '0;
      owner_q    <= '0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      owner_q    <= owner_d;
      btn_prev_q <= btn;
    end
  end

  // Next-state logic: start, delay to first repeat, periodic repeat, abort.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    owner_d = owner_q;
    fire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press_ok) begin
          fire    = 1'b1;
          owner_d = rise;
          rcnt_d  = '0;
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (abort) begin
          rcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (rcnt_q == DELAY_LAST) begin
          fire    = 1'b1;
          rcnt_d  = '0;
          state_d = ST_REPEAT;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      ST_REPEAT: begin
        if (abort) begin
          rcnt_d  = '0;
          state_d = ST_IDLE;
        end else if (rcnt_q == PERIOD_LAST) begin
          fire   = 1'b1;
          rcnt_d = '0;
        end else begin
          rcnt_d = rcnt_q + RCW'(1);
        end
      end
      default: begin
        rcnt_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic: a fire event selects the owning button's pulse line.
  always_comb begin
    pulse_d = fire ? owner_d : 3'b000;
  end

  // Pulse register so the step outputs come straight from flops.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= pulse_d;
    end
  end

  assign hour_id_o    = pulse_q[0];
  assign minute_id_o  = pulse_q[1];
  assign seconds_id_o = pulse_q[2];

endmodule

// File: tb/tb_tt_bin_clock_input_cond.sv
// Testbench for tt_bin_clock_input_cond: table of input steps, hand-timed
// sequences for repeat/abort corner cases, and a randomized run checked every
// cycle against an elapsed-time reference model.
module tb_tt_bin_clock_input_cond;

  localparam int S  = 2;
  localparam int D  = 3;
  localparam int RD = 50;
  localparam int RP = 10;

  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic time_set_sw_i = 1'b0, id_sw_i = 1'b0;
  logic hour_btn_i = 1'b0, minute_btn_i = 1'b0, seconds_btn_i = 1'b0;
  logic time_set_o, id_switch_o, hour_id_o, minute_id_o, seconds_id_o;

  tt_bin_clock_input_cond #(
    .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .time_set_sw_i(time_set_sw_i), .id_sw_i(id_sw_i),
    .hour_btn_i(hour_btn_i), .minute_btn_i(minute_btn_i), .seconds_btn_i(seconds_btn_i),
    .time_set_o(time_set_o), .id_switch_o(id_switch_o),
    .hour_id_o(hour_id_o), .minute_id_o(minute_id_o), .seconds_id_o(seconds_id_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int hq[$], mq[$], sq[$];

  // Reference model state: raw history, debounced levels, run lengths,
  // and the active press (owner + edge it started on).
  logic [4:0] m_hist[$];
  logic [4:0] m_deb;
  int         m_run[5];
  logic [2:0] m_prev;
  bit         m_active;
  logic [2:0] m_owner;
  int         m_start;
  logic [2:0] m_pulse;

  task automatic model_step();
    logic [4:0] raw, sv;
    logic [2:0] btn, rise;
    logic       ts;
    int         k;
    if (!reset_ni) begin
      m_hist.delete();
      for (int i = 0; i < S; i++) m_hist.push_back(5'b0);
      m_deb = '0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
      m_prev = '0;
      m_active = 1'b0;
      m_owner = '0;
      m_pulse = '0;
      return;
    end
    raw = {seconds_btn_i, minute_btn_i, hour_btn_i, id_sw_i, time_set_sw_i};
    sv  = m_hist.pop_front();
    m_hist.push_back(raw);
    btn  = m_deb[4:2];
    ts   = m_deb[0];
    rise = btn & ~m_prev;
    m_pulse = '0;
    if (!m_active) begin
      if (ts && $countones(rise) == 1 && btn == rise) begin
        m_active = 1'b1;
        m_owner  = rise;
        m_start  = edge_n;
        m_pulse  = rise;
      end
    end else if (!ts || btn != m_owner) begin
      m_active = 1'b0;
    end else begin
      k = edge_n - m_start;
      if (k == RD || (k > RD && (k - RD) % RP == 0)) m_pulse = m_owner;
    end
    m_prev = btn;
    for (int i = 0; i < 5; i++) begin
      if (sv[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_deb[i] = sv[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  // Per-cycle checker and pulse recorder, sampling 1 time unit after each edge.
  initial begin
    logic [4:0] got, want;
    forever begin
      @(posedge clk_i);
      edge_n++;
      model_step();
      #1;
      got  = {time_set_o, id_switch_o, hour_id_o, minute_id_o, seconds_id_o};
      want = {m_deb[0], m_deb[1], m_pulse[0], m_pulse[1], m_pulse[2]};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL model_cycle edge=%0d got=%b want=%b (ts,id,h,m,s)", edge_n, got, want);
      end
      if (hour_id_o)    hq.push_back(edge_n);
      if (minute_id_o)  mq.push_back(edge_n);
      if (seconds_id_o) sq.push_back(edge_n);
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic check_pulses(input string name, input int which, input int n, input int base,
                              input int o0, input int o1, input int o2, input int o3);
    int got[$];
    int offs[4];
    case (which)
      0:       got = hq;
      1:       got = mq;
      default: got = sq;
    endcase
    offs = '{o0, o1, o2, o3};
    check({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) check(name, got[i] - base, offs[i]);
  endtask

  task automatic clear_q();
    hq.delete(); mq.delete(); sq.delete();
  endtask

  task automatic set_raw(input logic ts, input logic id, input logic hr, input logic mn, input logic sc);
    time_set_sw_i = ts; id_sw_i = id; hour_btn_i = hr; minute_btn_i = mn; seconds_btn_i = sc;
  endtask

  task automatic apply_reset(input logic lvl);
    @(negedge clk_i);
    reset_ni = 1'b0;
    set_raw(lvl, lvl, lvl, lvl, lvl);
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clk_i);
  endtask

  typedef struct {
    logic ts, id, hr, mn, sc;
    int   hold;
    logic ts_o, id_o;
    int   nh, nm, ns;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int e0, p, e2;

    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 0, 0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b1, 0, 0, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b1, 0, 0, 1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 0, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0, 0, 0, 0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8, 1'b1, 1'b1, 0, 1, 0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b1, 0, 0, 0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8, 1'b1, 1'b1, 0, 0, 0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b1, 0, 0, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b1, 0, 0, 0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0, 0, 0, 0};

    // Reset with every raw input high, release, then async reset mid-run.
    apply_reset(1'b1);
    reset_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_outputs_held",
          {time_set_o, id_switch_o, hour_id_o, minute_id_o, seconds_id_o}, 0);
    clear_q();
    reset_ni = 1'b1;
    repeat (20) @(negedge clk_i);
    check("ts_after_release", time_set_o, 1);
    check("simultaneous_rise_no_pulse", hq.size() + mq.size() + sq.size(), 0);
    #2;
    reset_ni = 1'b0;
    #1;
    check("async_rst_outputs",
          {time_set_o, id_switch_o, hour_id_o, minute_id_o, seconds_id_o}, 0);

    // Table of input steps starting from a clean reset.
    apply_reset(1'b0);
    for (int r = 0; r < 12; r++) begin
      set_raw(vecs[r].ts, vecs[r].id, vecs[r].hr, vecs[r].mn, vecs[r].sc);
      clear_q();
      repeat (vecs[r].hold) @(negedge clk_i);
      check($sformatf("row%0d_levels", r), {time_set_o, id_switch_o}, {vecs[r].ts_o, vecs[r].id_o});
      check($sformatf("row%0d_pulses", r), hq.size() * 100 + mq.size() * 10 + sq.size(),
            vecs[r].nh * 100 + vecs[r].nm * 10 + vecs[r].ns);
    end

    // Debounce latency of the time-set level and first-pulse timing.
    apply_reset(1'b0);
    e0 = edge_n + 1;
    time_set_sw_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check("ts_before_edge4", time_set_o, 0);
    @(negedge clk_i);
    check("ts_at_edge4", time_set_o, 1);
    repeat (5) @(negedge clk_i);
    clear_q();
    e0 = edge_n + 1;
    seconds_btn_i = 1'b1;
    repeat (20) @(negedge clk_i);
    seconds_btn_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check_pulses("sec_single", 2, 1, e0, S + D, 0, 0, 0);
    check("sec_other_lines", hq.size() + mq.size(), 0);

    // Glitch shorter than the debounce window.
    clear_q();
    seconds_btn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    seconds_btn_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check("glitch_no_pulse", sq.size(), 0);

    // Hold-to-repeat on the minute button.
    clear_q();
    e0 = edge_n + 1;
    p  = e0 + S + D;
    minute_btn_i = 1'b1;
    wait_edge(p + 71);
    minute_btn_i = 1'b0;
    repeat (100) @(negedge clk_i);
    check_pulses("min_repeat", 1, 4, p, 0, 50, 60, 70);

    // Second button during repeat aborts; re-press is required.
    clear_q();
    e0 = edge_n + 1;
    p  = e0 + S + D;
    hour_btn_i = 1'b1;
    wait_edge(p + 51);
    minute_btn_i = 1'b1;
    repeat (20) @(negedge clk_i);
    minute_btn_i = 1'b0;
    repeat (30) @(negedge clk_i);
    check_pulses("hour_abort", 0, 2, p, 0, 50, 0, 0);
    check("minute_during_abort", mq.size(), 0);
    hour_btn_i = 1'b0;
    repeat (10) @(negedge clk_i);
    e2 = edge_n + 1;
    hour_btn_i = 1'b1;
    repeat (20) @(negedge clk_i);
    hour_btn_i = 1'b0;
    repeat (10) @(negedge clk_i);
    check_pulses("hour_repress", 0, 3, p, 0, 50, e2 + S + D - p, 0);

    // Time-set gating: no pulse with time-set low or when it rises mid-hold.
    time_set_sw_i = 1'b0;
    repeat (10) @(negedge clk_i);
    clear_q();
    hour_btn_i = 1'b1;
    repeat (15) @(negedge clk_i);
    time_set_sw_i = 1'b1;
    repeat (20) @(negedge clk_i);
    check("hold_before_ts", hq.size(), 0);
    hour_btn_i = 1'b0;
    repeat (10) @(negedge clk_i);
    clear_q();
    e0 = edge_n + 1;
    p  = e0 + S + D;
    hour_btn_i = 1'b1;
    wait_edge(p + 19);
    time_set_sw_i = 1'b0;
    wait_edge(p + 70);
    check_pulses("ts_drop_in_delay", 0, 1, p, 0, 0, 0, 0);
    hour_btn_i = 1'b0;

    // Randomized run, checked every cycle by the reference model.
    apply_reset(1'b0);
    for (int seg = 0; seg < 300; seg++) begin
      int hold;
      set_raw($urandom_range(0, 9) < 8, $urandom_range(0, 1) == 1,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      hold = ($urandom_range(0, 15) == 0) ? $urandom_range(55, 80) : $urandom_range(1, 12);
      repeat (hold) @(negedge clk_i);
    end
    set_raw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk_i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tt_bin_clock_input_cond.md
Name: tt_bin_clock_input_cond

Overview:
Input conditioner that sits directly upstream of the binary clock core. It takes raw board switches and push-buttons, then synchronises and debounces each one. It drives the core's time_set and id_switch levels, plus one-cycle hour/minute/seconds step pulses with hold-to-auto-repeat. The core therefore receives exactly one increment/decrement request per press, or per repeat tick, instead of one per 100 Hz clock while a button is held.

Parameters:
SYNC_STAGES, 2, synchroniser flops per raw input (must be >=2)
DEBOUNCE_CYCLES, 3, consecutive cycles a synchronised input must differ from its debounced level before that level flips (>=1; 30 ms at 100 Hz)
REPEAT_DELAY, 50, cycles from the first step pulse to the first repeat pulse (>=REPEAT_PERIOD)
REPEAT_PERIOD, 10, cycles between subsequent repeat pulses (>=1)

Ports:
clk_i  input  1  system clock, 100 Hz
reset_ni  input  1  asynchronous active-low reset
time_set_sw_i  input  1  raw time-set switch, active-high, asynchronous
id_sw_i  input  1  raw increment(1)/decrement(0) switch, asynchronous
hour_btn_i  input  1  raw hour button, active-high, asynchronous
minute_btn_i  input  1  raw minute button, active-high, asynchronous
seconds_btn_i  input  1  raw seconds button, active-high, asynchronous
time_set_o  output  1  debounced time-set level
id_switch_o  output  1  debounced inc/dec level
hour_id_o  output  1  hour step pulse (one cycle)
minute_id_o  output  1  minute step pulse (one cycle)
seconds_id_o  output  1  seconds step pulse (one cycle)

Behaviour:
- Reset (reset_ni=0, async assert): all sync flops, debounced levels, counters and outputs are 0; FSM=IDLE. Release is synchronous to clk_i.
- Per input: SYNC_STAGES-flop chain -> debounce counter. On each edge where sync!=debounced: if cnt==DEBOUNCE_CYCLES-1, debounced<=sync and cnt<=0; else cnt++. On any edge where sync==debounced: cnt<=0.
- Latency: a raw level change held stable flips the debounced level on rising edge SYNC_STAGES+DEBOUNCE_CYCLES-1, counting from edge 0, the first edge that samples the new level (edge 4 with defaults). A glitch shorter than DEBOUNCE_CYCLES synchronised cycles produces no change.
- time_set_o and id_switch_o are the debounced levels, driven straight from flops.
- Step FSM over the debounced buttons. Owner = the single button that started the sequence. States:
  - IDLE: on an edge where exactly one debounced button has a rising edge (was 0, now 1), no other button is held, and time_set_o=1: assert its pulse, latch owner, rcnt<=0, go to DELAY.
  - DELAY: rcnt++ each cycle. When rcnt==REPEAT_DELAY-1: pulse the owner, rcnt<=0, go to REPEAT.
  - REPEAT: rcnt++. When rcnt==REPEAT_PERIOD-1: pulse the owner, rcnt<=0.
  - Abort from DELAY/REPEAT to IDLE, with no pulse that cycle and rcnt<=0, on any of: owner released, any other button pressed, or time_set_o=0.
- Pulses are registered and high for exactly one cycle. The first pulse is high in the cycle after the debounced rise, i.e. it is set on edge S+D with defaults (edge 5). At most one of the three pulse outputs is high in any cycle.
- Repeat timing: the first pulse sets on edge P; later pulses set on P+REPEAT_DELAY, then every REPEAT_PERIOD edges (defaults: P, P+50, P+60, P+70...).
- A button already held when time_set_o rises, or still held after an abort, never pulses. It must be released (debounced 0) and pressed again.
- Two buttons rising on the same edge produces no pulse; the FSM stays IDLE.
- id_switch_o may change during a repeat. No effect on the FSM; the core samples it per pulse.
- Raw buttons high at reset release are treated as a genuine rise. They pulse if time_set_o is also 1 at detection.
- Counter widths: $clog2 of the max count + 1. No wrap is possible, because counters clear at their terminal value.

Test Plan:
- Reset with all raw inputs 1, deassert reset_ni, then assert it mid-operation -> all outputs 0 immediately, regardless of clock; FSM IDLE.
- time_set_sw_i=1 held, then seconds_btn_i 0->1 held 20 cycles from edge 0 -> time_set_o high after edge 4; seconds_id_o high only in the cycle after the press's edge-5 equivalent; one pulse total.
- seconds_btn_i glitches high for 2 cycles (D=3) -> debounced level and all pulses stay 0.
- time_set=1, minute_btn_i held 75 cycles past first pulse edge P -> minute_id_o pulses at P, P+50, P+60, P+70 only; nothing after release.
- While hour button is in REPEAT, press minute_btn_i -> no further pulses on either output. Release minute -> hour still held, still no pulse. Release and re-press hour -> one hour pulse.
- time_set=0, press hour_btn_i -> no pulse. Raise time_set while hour held -> no pulse. During DELAY, drop time_set -> no repeat pulse at P+50.
